// File: rtl/mips_pkg.sv
// Shared constants for the MIPS front end: bus widths, HALT opcode and
// program-loader state encoding.
package mips_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_BYTE_WIDTH = 8;
  localparam int unsigned DEF_SIZEOP     = 6;

  // Same opcode the instruction memory decodes as end-of-program.
  localparam logic [5:0] HALT_OP = 6'b111111;

  localparam int unsigned STATE_W = 3;
  typedef logic [STATE_W-1:0] state_t;

  localparam state_t IDLE  = 3'd0;
  localparam state_t LOAD  = 3'd1;
  localparam state_t DRAIN = 3'd2;
  localparam state_t DONE  = 3'd3;
  localparam state_t ERROR = 3'd4;

  function automatic logic is_halt(input logic [5:0] opcode);
    return opcode == HALT_OP;
  endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input and memory load-port output bundle of the program loader.
interface program_loader_if #(
  parameter int unsigned DATA_WIDTH = mips_pkg::DEF_DATA_WIDTH,
  parameter int unsigned BYTE_WIDTH = mips_pkg::DEF_BYTE_WIDTH
);

  logic                  i_start;
  logic [BYTE_WIDTH-1:0] i_rx_data;
  logic                  i_rx_valid;
  logic [DATA_WIDTH-1:0] o_instruccion;
  logic [DATA_WIDTH-1:0] o_address;
  logic                  o_loading;
  logic [DATA_WIDTH-1:0] o_word_count;
  logic                  o_done;
  logic                  o_error;

  // master: byte source / session controller; slave: the loader itself
  modport master (
    output i_start, i_rx_data, i_rx_valid,
    input  o_instruccion, o_address, o_loading, o_word_count, o_done, o_error
  );

  modport slave (
    input  i_start, i_rx_data, i_rx_valid,
    output o_instruccion, o_address, o_loading, o_word_count, o_done, o_error
  );

endinterface

// File: rtl/program_loader_byte_packer.sv
// Packs a big-endian byte stream into words; pulses word_valid_c on the
// cycle the last byte of a word is presented.
module byte_packer #(
  parameter int unsigned DATA_WIDTH = mips_pkg::DEF_DATA_WIDTH,
  parameter int unsigned BYTE_WIDTH = mips_pkg::DEF_BYTE_WIDTH
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  clear,
  input  logic                  byte_en,
  input  logic [BYTE_WIDTH-1:0] byte_data,
  output logic                  word_valid_c,
  output logic [DATA_WIDTH-1:0] word_c
);

  localparam int unsigned BYTES_PER_WORD = DATA_WIDTH / BYTE_WIDTH;
  localparam int unsigned CNT_W          = $clog2(BYTES_PER_WORD);
  localparam int unsigned HELD_W         = DATA_WIDTH - BYTE_WIDTH;

  logic [CNT_W-1:0]  byte_cnt;
  logic [HELD_W-1:0] shift_reg;

  // Only the bytes still needed for the current word are kept.
  assign word_c       = {shift_reg, byte_data};
  assign word_valid_c = byte_en && (byte_cnt == CNT_W'(BYTES_PER_WORD - 1));

  always_ff @(posedge i_clock) begin
    if (i_reset || clear) begin
      byte_cnt  <= '0;
      shift_reg <= '0;
    end else if (byte_en) begin
      shift_reg <= word_c[HELD_W-1:0];
      byte_cnt  <= word_valid_c ? '0 : byte_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/program_loader.sv
// Writer side of the instruction-memory load port: packs UART bytes into
// instructions, writes consecutive words and stops at the first HALT.
module program_loader #(
  parameter int unsigned DATA_WIDTH = mips_pkg::DEF_DATA_WIDTH,
  parameter int unsigned BYTE_WIDTH = mips_pkg::DEF_BYTE_WIDTH,
  parameter int unsigned MEM_DEPTH  = 32,
  parameter int unsigned SIZEOP     = mips_pkg::DEF_SIZEOP
) (
  input logic             i_clock,
  input logic             i_reset,
  program_loader_if.slave bus
);

  import mips_pkg::*;

  state_t state;
  state_t state_next;

  logic                  word_valid_c;
  logic [DATA_WIDTH-1:0] word_c;
  logic                  full_c;
  logic                  start_accept_c;
  logic                  byte_en_c;
  logic                  halt_c;

  logic                  loading_d;
  logic                  done_d;
  logic                  error_d;

  logic [DATA_WIDTH-1:0] instr_q;
  logic [DATA_WIDTH-1:0] address_q;
  logic [DATA_WIDTH-1:0] word_count_q;
  logic                  loading_q;
  logic                  done_q;
  logic                  error_q;

  assign full_c         = word_count_q == DATA_WIDTH'(MEM_DEPTH);
  assign start_accept_c = bus.i_start && (state == IDLE || state == DONE || state == ERROR);
  // A byte arriving with the memory already full is dropped, not packed.
  assign byte_en_c      = (state == LOAD) && bus.i_rx_valid && !full_c;
  assign halt_c         = is_halt(6'(word_c[DATA_WIDTH-1 -: SIZEOP]));

  byte_packer #(
    .DATA_WIDTH (DATA_WIDTH),
    .BYTE_WIDTH (BYTE_WIDTH)
  ) u_packer (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .clear        (start_accept_c),
    .byte_en      (byte_en_c),
    .byte_data    (bus.i_rx_data),
    .word_valid_c (word_valid_c),
    .word_c       (word_c)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE, DONE, ERROR: if (bus.i_start) state_next = LOAD;
      LOAD: begin
        if (bus.i_rx_valid && full_c)     state_next = ERROR;
        else if (word_valid_c && halt_c)  state_next = DRAIN;
      end
      DRAIN:   state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  // Status levels are decoded from the upcoming state and then registered.
  always_comb begin
    loading_d = 1'b0;
    done_d    = 1'b0;
    error_d   = 1'b0;
    unique case (state_next)
      LOAD, DRAIN: loading_d = 1'b1;
      DONE:        done_d    = 1'b1;
      ERROR:       error_d   = 1'b1;
      default:     ;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      instr_q      <= '0;
      address_q    <= '0;
      word_count_q <= '0;
      loading_q    <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      loading_q <= loading_d;
      done_q    <= done_d;
      error_q   <= error_d;
      if (start_accept_c) begin
        address_q    <= '0;
        word_count_q <= '0;
      end else if (word_valid_c) begin
        instr_q      <= word_c;
        address_q    <= word_count_q;
        word_count_q <= word_count_q + DATA_WIDTH'(1);
      end
    end
  end

  assign bus.o_instruccion = instr_q;
  assign bus.o_address     = address_q;
  assign bus.o_word_count  = word_count_q;
  assign bus.o_loading     = loading_q;
  assign bus.o_done        = done_q;
  assign bus.o_error       = error_q;

endmodule

// File: tb/tb_program_loader.sv
// Randomized self-checking bench for program_loader against a session-level
// model of the byte stream, plus a negedge-written instruction memory.
module tb_program_loader;

  localparam int M_IDLE  = 0;
  localparam int M_LOAD  = 1;
  localparam int M_DRAIN = 2;
  localparam int M_DONE  = 3;
  localparam int M_ERROR = 4;
  localparam int DEPTH   = 32;

  typedef struct {
    int          ph;
    logic [31:0] instr;
    logic [31:0] addr;
    logic [31:0] wc;
    logic [31:0] acc;
    int          nbytes;
  } mdl_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  program_loader_if #(.DATA_WIDTH(32), .BYTE_WIDTH(8)) bus ();

  program_loader #(
    .DATA_WIDTH (32),
    .BYTE_WIDTH (8),
    .MEM_DEPTH  (DEPTH),
    .SIZEOP     (6)
  ) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int bad_write = 0;
  bit check_en = 1'b0;
  bit stray_start = 1'b0;
  mdl_t m = '{ph: M_IDLE, instr: 0, addr: 0, wc: 0, acc: 0, nbytes: 0};
  logic [31:0] mem [DEPTH];
  logic [31:0] golden [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Session-level view: every fourth accepted byte completes a word.
  function automatic mdl_t model_step(input mdl_t cur, input logic r, input logic start,
                                      input logic valid, input logic [7:0] data);
    mdl_t n = cur;
    if (r) begin
      n.ph = M_IDLE; n.instr = 0; n.addr = 0; n.wc = 0; n.acc = 0; n.nbytes = 0;
      return n;
    end
    case (cur.ph)
      M_LOAD: if (valid) begin
        if (cur.wc == 32'(DEPTH)) n.ph = M_ERROR;
        else begin
          n.acc    = {cur.acc[23:0], data};
          n.nbytes = cur.nbytes + 1;
          if ((n.nbytes % 4) == 0) begin
            n.instr = n.acc;
            n.addr  = cur.wc;
            n.wc    = cur.wc + 1;
            if (n.acc[31:26] == 6'h3f) n.ph = M_DRAIN;
          end
        end
      end
      M_DRAIN: n.ph = M_DONE;
      default: if (start) begin
        n.ph = M_LOAD; n.addr = 0; n.wc = 0; n.acc = 0; n.nbytes = 0;
      end
    endcase
    return n;
  endfunction

  always @(posedge clk)
    m <= model_step(m, rst, bus.i_start, bus.i_rx_valid, bus.i_rx_data);

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (check_en) begin
      check("instruccion", bus.o_instruccion, m.instr);
      check("address",     bus.o_address,     m.addr);
      check("word_count",  bus.o_word_count,  m.wc);
      check("loading", 32'(bus.o_loading), 32'(m.ph == M_LOAD || m.ph == M_DRAIN));
      check("done",    32'(bus.o_done),    32'(m.ph == M_DONE));
      check("error",   32'(bus.o_error),   32'(m.ph == M_ERROR));
    end
  end

  // Instruction memory: writes on every negedge while loading.
  always @(negedge clk) begin
    if (bus.o_loading === 1'b1) begin
      if (bus.o_address < 32'(DEPTH)) mem[bus.o_address[4:0]] = bus.o_instruccion;
      else bad_write++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    for (int g = 0; g < gap; g++) begin
      bus.i_start = stray_start && ($urandom_range(0, 7) == 0);
      tick();
      bus.i_start = 1'b0;
    end
    bus.i_rx_valid = 1'b1;
    bus.i_rx_data  = b;
    tick();
    bus.i_rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int maxgap);
    for (int b = 0; b < 4; b++) send_byte(w[31-8*b -: 8], $urandom_range(0, maxgap));
  endtask

  task automatic start_session(input bit with_byte);
    bus.i_start = 1'b1;
    if (with_byte) begin
      bus.i_rx_valid = 1'b1;
      bus.i_rx_data  = 8'($urandom);
    end
    tick();
    bus.i_start    = 1'b0;
    bus.i_rx_valid = 1'b0;
  endtask

  task automatic junk(input int n);
    for (int k = 0; k < n; k++) begin
      bus.i_rx_valid = 1'($urandom_range(0, 1));
      bus.i_rx_data  = 8'($urandom);
      tick();
    end
    bus.i_rx_valid = 1'b0;
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w = $urandom;
    if (w[31:26] == 6'h3f) w[26] = 1'b0;
    return w;
  endfunction

  task automatic check_mem();
    for (int i = 0; i < golden.size(); i++)
      check($sformatf("mem[%0d]", i), mem[i], golden[i]);
  endtask

  task automatic wait_done();
    int k = 0;
    while (bus.o_done !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    check("done_wait", 32'(bus.o_done), 32'd1);
  endtask

  initial begin
    logic [31:0] w;
    int nw;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    bus.i_start    = 1'b0;
    bus.i_rx_valid = 1'b0;
    bus.i_rx_data  = '0;
    rst = 1'b1;
    tick();
    check_en = 1'b1;
    tick();
    rst = 1'b0;

    // Idle: stray bytes without a start change nothing.
    junk(10);
    check("idle_loading", 32'(bus.o_loading), 32'd0);
    check("idle_done",    32'(bus.o_done),    32'd0);
    check("idle_error",   32'(bus.o_error),   32'd0);
    check("idle_address", bus.o_address,      32'd0);

    // Directed program of three words then HALT.
    golden = '{32'h20010005, rand_word(), rand_word(), 32'hFC000000};
    start_session(1'b0);
    send_word(golden[0], 2);
    check("w0_instr",   bus.o_instruccion, 32'h20010005);
    check("w0_addr",    bus.o_address,     32'd0);
    check("w0_count",   bus.o_word_count,  32'd1);
    check("w0_loading", 32'(bus.o_loading), 32'd1);
    for (int i = 1; i < 4; i++) send_word(golden[i], 2);
    check("halt_addr",    bus.o_address,      32'd3);
    check("halt_instr",   bus.o_instruccion,  32'hFC000000);
    check("drain_loading", 32'(bus.o_loading), 32'd1);
    tick();
    check("done_loading", 32'(bus.o_loading), 32'd0);
    check("done_flag",    32'(bus.o_done),    32'd1);
    check("done_count",   bus.o_word_count,   32'd4);
    check_mem();
    junk(4);

    // Random programs with variable byte spacing.
    stray_start = 1'b1;
    for (int s = 0; s < 5; s++) begin
      nw = $urandom_range(1, 8);
      golden.delete();
      for (int i = 0; i < nw; i++) golden.push_back(rand_word());
      golden.push_back({6'h3f, 26'($urandom)});
      start_session(1'($urandom_range(0, 1)));
      foreach (golden[i]) send_word(golden[i], 5);
      junk(2);
      wait_done();
      check("rand_count", bus.o_word_count, 32'(nw + 1));
      check_mem();
    end
    stray_start = 1'b0;

    // Overflow: 32 ordinary words then one more byte.
    golden.delete();
    for (int i = 0; i < DEPTH; i++) golden.push_back(rand_word());
    start_session(1'b0);
    foreach (golden[i]) send_word(golden[i], 1);
    check("full_loading", 32'(bus.o_loading), 32'd1);
    send_byte(8'hFC, 0);
    check("ovf_error",   32'(bus.o_error),   32'd1);
    check("ovf_loading", 32'(bus.o_loading), 32'd0);
    check("ovf_count",   bus.o_word_count,   32'd32);
    junk(3);
    check_mem();

    // Reset in the middle of word 5, then a fresh session from address 0.
    start_session(1'b0);
    for (int i = 0; i < 5; i++) send_word(rand_word(), 2);
    send_byte(8'h12, 1);
    send_byte(8'h34, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_loading", 32'(bus.o_loading), 32'd0);
    check("rst_count",   bus.o_word_count,   32'd0);
    tick();
    start_session(1'b0);
    w = rand_word();
    send_word(w, 1);
    check("restart_addr",  bus.o_address,     32'd0);
    check("restart_count", bus.o_word_count,  32'd1);
    check("restart_instr", bus.o_instruccion, w);
    tick();

    check("no_write_beyond", 32'(bad_write), 32'd0);
    check_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Writer side of the instruction-memory load port.
- Takes a byte stream from the UART receiver (`i_rx_data` / `i_rx_valid`), packs every 4 bytes into one 32-bit instruction and writes it to consecutive word addresses.
- Drives the instruction memory's instruction/address/loading inputs and holds the CPU off fetch while loading.
- Loading ends at the first word whose opcode is HALT (6'b111111). An error is flagged if memory depth is exceeded first.

Parameters:
- DATA_WIDTH, 32, instruction and address width.
- BYTE_WIDTH, 8, width of incoming serial byte.
- MEM_DEPTH, 32, number of instruction words in the target memory.
- SIZEOP, 6, opcode field width (bits [31:26]).

Ports:
- i_clock  in  1  system clock; all logic on posedge.
- i_reset  in  1  reset.
- i_start  in  1  one-cycle request to begin a load session.
- i_rx_data  in  BYTE_WIDTH  received byte.
- i_rx_valid  in  1  one-cycle strobe; i_rx_data is valid.
- o_instruccion  out  DATA_WIDTH  assembled word to memory.
- o_address  out  DATA_WIDTH  word address to memory.
- o_loading  out  1  level; memory write enable and fetch inhibit.
- o_word_count  out  DATA_WIDTH  words committed this session.
- o_done  out  1  level; load finished with HALT.
- o_error  out  1  level; overflow, session aborted.

Behaviour:
- Reset:
  - Reset i_reset, synchronous, active-high; it dominates every other input.
  - Reset values: state IDLE; o_instruccion 0; o_address 0; o_loading 0; o_word_count 0; o_done 0; o_error 0; byte counter 0; shift register 0.
  - Reset mid-session abandons the session immediately: o_loading drops on the next edge and already written words are not cleared.
- States: IDLE, LOAD, DRAIN, DONE, ERROR.
- IDLE:
  - o_loading=0.
  - i_start moves to LOAD and clears o_address, o_word_count, byte counter, shift register, o_done and o_error.
  - i_rx_valid in IDLE is ignored.
- LOAD:
  - o_loading=1.
  - Each i_rx_valid shifts the byte in, big-endian: first byte lands in [31:24], fourth in [7:0].
  - byte counter wraps 0..3.
  - On the edge that samples the 4th byte:
    - o_instruccion takes the full word (the shift register with the new byte).
    - o_address takes o_word_count.
    - o_word_count increments.
    - All three update on the same edge, so the outputs are visible in the following cycle.
  - o_instruccion and o_address change only at word commits. The memory writes on every negedge while o_loading is high, so repeated writes of the held word are idempotent and required behaviour.
  - If the committed word has [31:26]==HALT, go to DRAIN; otherwise stay in LOAD.
  - Overflow: an i_rx_valid while o_word_count==MEM_DEPTH goes to ERROR. That byte is discarded and nothing is written.
  - i_start in LOAD is ignored.
- DRAIN:
  - o_loading stays 1 for exactly one cycle, so the HALT word is captured by a negedge.
  - Then go to DONE.
  - i_rx_valid in DRAIN is ignored.
- DONE:
  - o_loading=0, o_done=1, o_instruccion and o_address hold.
  - i_start starts a new session; i_rx_valid is ignored.
- ERROR:
  - o_loading=0, o_error=1.
  - Leave only via i_start (back to LOAD, flags cleared) or reset.
- Simultaneous i_start and i_rx_valid in IDLE/DONE/ERROR: start wins and the byte is dropped.
- Address width: o_address is zero-extended from the word index; the index never exceeds MEM_DEPTH-1.

Decomposition:
- Shared package `mips_pkg` holds:
  - HALT opcode constant 6'b111111 (same value the memory decodes).
  - State encoding localparams IDLE/LOAD/DRAIN/DONE/ERROR.
  - DATA_WIDTH and BYTE_WIDTH defaults.
- One natural sub-module: `byte_packer`. It contains the shift register and mod-4 byte counter, and emits a word_valid pulse plus the word. The FSM and address/commit logic stay in program_loader.

Test Plan:
- Reset then idle: o_loading=0, o_done=0, o_error=0, o_address=0 for 10 cycles; bytes with no i_start produce no change.
- i_start, then bytes 20 01 00 05 → after 4th strobe o_instruccion=0x20010005, o_address=0, o_word_count=1, o_loading=1.
- Three words then FC 00 00 00 → HALT word written at o_address=3; o_loading high exactly one extra cycle; then o_done=1, o_loading=0, o_word_count=4.
- Bytes spaced 0..5 idle cycles apart, plus the 4th byte of a word arriving together with the next word's first on consecutive cycles → packing unaffected; memory model contents match the golden program.
- 32 non-HALT words then one more byte → o_error=1, o_loading=0, memory address 31 holds word 31, no write beyond.
- Reset asserted after 2 bytes of word 5 → next cycle o_loading=0, state IDLE; a new i_start load begins at o_address=0.
